des_key_schedule_rev: RTL and testbench

- Sequential DES key-schedule engine that produces the 16 round subkeys in decryption order: K16 first, then down to K1.
- It is the reverse-direction counterpart of the existing single-round forward key step. It applies PC-1 once, then applies right rotations to C/D, applying PC-2 each round.
- It sits between the key register and the round datapath when the core runs in decrypt mode, with a valid/ready stream towards the datapath.
- A parameter lets the same engine emit encryption order (K1..K16) for reuse.

---
 rtl/des_key_schedule_rev_if.sv | 26 ++
 rtl/des_key_schedule_rev.sv | 123 ++++++++++++
 tb/tb_des_key_schedule_rev.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/des_key_schedule_rev_if.sv
// Key-schedule stream bundle: start/key request in, subkey valid/ready stream out.
// With DES_KEY_PARITY_CHECK_EN defined the bundle also carries key_parity_err.
interface des_key_schedule_rev_if;
    logic        start;
    logic [1:64] key_in;
    logic [1:48] round_key;
    logic [4:0]  round_num;
    logic        key_valid;
    logic        key_ready;
    logic        key_last;
    logic        busy;
    logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        key_parity_err;

    modport master (output start, key_in, key_ready,
                    input  round_key, round_num, key_valid, key_last, busy, done, key_parity_err);
    modport slave  (input  start, key_in, key_ready,
                    output round_key, round_num, key_valid, key_last, busy, done, key_parity_err);
`else
    modport master (output start, key_in, key_ready,
                    input  round_key, round_num, key_valid, key_last, busy, done);
    modport slave  (input  start, key_in, key_ready,
                    output round_key, round_num, key_valid, key_last, busy, done);
`endif
endinterface

// File: rtl/des_key_schedule_rev.sv
// Sequential DES subkey generator: K16..K1 via right rotations (KEY_ORDER=1) or K1..K16 via
// left rotations (KEY_ORDER=0). Optional key parity flag under DES_KEY_PARITY_CHECK_EN.
module des_key_schedule_rev #(
    parameter int KEY_ORDER = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    des_key_schedule_rev_if.slave bus
);
    localparam int PC1_TAB [56] = '{
        57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
        10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    localparam int PC2_TAB [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,
        23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,
        44,49,39,56,34,53,46,42,50,36,29,32};
    localparam bit       DEC      = (KEY_ORDER != 0);
    localparam logic [4:0] FIRST_RN = DEC ? 5'd16 : 5'd1;
    localparam logic [4:0] LAST_RN  = DEC ? 5'd1  : 5'd16;

    function automatic logic [1:56] pc1(input logic [1:64] k);
        pc1 = '0;
        for (int i = 1; i <= 56; i++) pc1[i] = k[PC1_TAB[i-1]];
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        pc2 = '0;
        for (int i = 1; i <= 48; i++) pc2[i] = cd[PC2_TAB[i-1]];
    endfunction

    // C and D halves rotate independently by one or two places
    function automatic logic [1:56] rot(input logic [1:56] cd, input logic right, input logic two);
        logic [1:28] c, d;
        c = cd[1:28];
        d = cd[29:56];
        if (right) begin
            c = two ? {c[27:28], c[1:26]} : {c[28], c[1:27]};
            d = two ? {d[27:28], d[1:26]} : {d[28], d[1:27]};
        end else begin
            c = two ? {c[3:28], c[1:2]} : {c[2:28], c[1]};
            d = two ? {d[3:28], d[1:2]} : {d[2:28], d[1]};
        end
        rot = {c, d};
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;
    state_t      state, state_nxt;
    logic [1:56] cd;
    logic [4:0]  rn, rn_nxt;
    logic        accept, xfer, last, one_step;

    assign accept = (state == S_IDLE) && bus.start;
    assign xfer   = bus.key_valid && bus.key_ready;
    assign last   = bus.key_valid && (rn == LAST_RN);
    assign rn_nxt = DEC ? rn - 5'd1 : rn + 5'd1;
    assign one_step = DEC ? (rn_nxt == 5'd15 || rn_nxt == 5'd8 || rn_nxt == 5'd1)
                          : (rn_nxt == 5'd1 || rn_nxt == 5'd2 || rn_nxt == 5'd9 || rn_nxt == 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_EMIT;
            S_EMIT:  if (xfer && last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // K16 needs no pre-rotation in decrypt order: the 28 left shifts of a full schedule cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd <= '0;
            rn <= '0;
        end else if (accept) begin
            cd <= DEC ? pc1(bus.key_in) : rot(pc1(bus.key_in), 1'b0, 1'b0);
            rn <= FIRST_RN;
        end else if (xfer) begin
            if (last) begin
                rn <= '0;
            end else begin
                cd <= rot(cd, DEC, !one_step);
                rn <= rn_nxt;
            end
        end
    end

    assign bus.key_valid = (state == S_EMIT);
    assign bus.busy      = (state == S_EMIT);
    assign bus.done      = (state == S_DONE);
    assign bus.key_last  = last;
    assign bus.round_num = rn;
    assign bus.round_key = bus.key_valid ? pc2(cd) : '0;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic perr;

    // DES keys carry odd parity per byte; any even byte flags the key
    function automatic logic any_even(input logic [1:64] k);
        any_even = 1'b0;
        for (int b = 0; b < 8; b++)
            if (!(^k[8*b+1 +: 8])) any_even = 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      perr <= 1'b0;
        else if (accept) perr <= any_even(bus.key_in);
    end

    assign bus.key_parity_err = perr;
`else
    logic unused_parity_bits;
    assign unused_parity_bits = ^{bus.key_in[8], bus.key_in[16], bus.key_in[24], bus.key_in[32],
                                  bus.key_in[40], bus.key_in[48], bus.key_in[56], bus.key_in[64]};
`endif
endmodule

// File: tb/tb_des_key_schedule_rev.sv
// Scoreboard bench: both key orders run side by side on shared stimulus against a
// cumulative-shift DES key schedule model.
module tb_des_key_schedule_rev;
    localparam logic [63:0] KNOWN = 64'h133457799BBCDFF1;
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
        10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    localparam int PC2_T [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,
        23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,
        44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct { logic [47:0] key; int rn; bit last; } exp_t;

    logic        clk, rst_n, start, key_ready;
    logic [63:0] key_in;
    int          total = 0, bad = 0;
    exp_t        q1[$], q0[$];
    bit          pend1 = 0, pend0 = 0;

    des_key_schedule_rev_if i1 ();
    des_key_schedule_rev_if i0 ();
    assign i1.start = start;  assign i1.key_in = key_in;  assign i1.key_ready = key_ready;
    assign i0.start = start;  assign i0.key_in = key_in;  assign i0.key_ready = key_ready;

    des_key_schedule_rev #(.KEY_ORDER(1)) dut_dec (.clk(clk), .rst_n(rst_n), .bus(i1));
    des_key_schedule_rev #(.KEY_ORDER(0)) dut_enc (.clk(clk), .rst_n(rst_n), .bus(i0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Forward schedule: Kr = PC2(rotl(C0, sum of shifts 1..r), rotl(D0, same))
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
        logic [55:0] cd;
        logic [55:0] c, d;
        logic [47:0] o;
        int s;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        s = 0;
        for (int i = 0; i < r; i++) s += SHIFTS[i];
        s = s % 28;
        c = {28'd0, cd[55:28]};
        d = {28'd0, cd[27:0]};
        c = ((c << s) | (c >> (28 - s))) & 56'hFFFFFFF;
        d = ((d << s) | (d >> (28 - s))) & 56'hFFFFFFF;
        cd = {c[27:0], d[27:0]};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
        return o;
    endfunction

    function automatic bit par_err(input logic [63:0] k);
        for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_exp(input logic [63:0] k);
        exp_t e;
        for (int r = 16; r >= 1; r--) begin
            e.key = ref_key(k, r);
            if (k == KNOWN) begin
                case (r)
                    16: e.key = 48'hCB3D8B0E17F5;
                    15: e.key = 48'hBF918D3D3F0A;
                    2:  e.key = 48'h79AED9DBC9E5;
                    1:  e.key = 48'h1B02EFFC7072;
                    default: ;
                endcase
            end
            e.rn = r; e.last = (r == 1);
            q1.push_back(e);
        end
        for (int r = 1; r <= 16; r++) begin
            e.key = ref_key(k, r); e.rn = r; e.last = (r == 16);
            q0.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pend1) begin chk("done_dec", {i1.done, i1.key_valid}, 2'b10); pend1 = 0; end
            else if (i1.done) chk("spurious_done_dec", i1.done, 0);
            if (i1.key_valid) begin
                if (q1.size() == 0) chk("unexpected_key_dec", i1.key_valid, 0);
                else begin
                    e = q1[0];
                    chk("key_dec", i1.round_key, e.key);
                    chk("rn_dec", i1.round_num, e.rn);
                    chk("last_dec", i1.key_last, e.last);
                    if (key_ready) begin pend1 = e.last; void'(q1.pop_front()); end
                end
            end else chk("idle_zero_dec", {i1.round_key, i1.key_last}, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pend0) begin chk("done_enc", {i0.done, i0.key_valid}, 2'b10); pend0 = 0; end
            else if (i0.done) chk("spurious_done_enc", i0.done, 0);
            if (i0.key_valid) begin
                if (q0.size() == 0) chk("unexpected_key_enc", i0.key_valid, 0);
                else begin
                    e = q0[0];
                    chk("key_enc", i0.round_key, e.key);
                    chk("rn_enc", i0.round_num, e.rn);
                    chk("last_enc", i0.key_last, e.last);
                    if (key_ready) begin pend0 = e.last; void'(q0.pop_front()); end
                end
            end else chk("idle_zero_enc", {i0.round_key, i0.key_last}, 0);
        end
    end

    // stall_at / ign_at / rst_at name a decrypt-order round_num (0 = unused)
    task automatic run_seq(input logic [63:0] k, input int stall_at, input int ign_at,
                           input int rst_at, input bit rnd);
        int stall = 0;
        bit stalled = 0, ignored = 0, fin = 0;
        @(posedge clk); #1;
        start = 1; key_in = k; key_ready = 1;
        push_exp(k);
        @(posedge clk); #1;
        start = 0; key_in = {$urandom, $urandom};
        chk("first_valid", {i1.key_valid, i1.busy, i0.key_valid, i0.busy}, 4'hF);
        chk("first_rn", {i1.round_num, i0.round_num}, {5'd16, 5'd1});
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("parity_err", {i1.key_parity_err, i0.key_parity_err}, {2{par_err(k)}});
`endif
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            start = 0;
            if (i1.done) begin
                fin = 1; start = 1; key_in = ~k;
            end else if (rst_at != 0 && i1.key_valid && i1.round_num == 5'(rst_at)) begin
                rst_n = 0; #1;
                chk("rst_dec", {i1.key_valid, i1.busy, i1.done, i1.key_last, i1.round_num, i1.round_key}, 0);
                chk("rst_enc", {i0.key_valid, i0.busy, i0.done, i0.key_last, i0.round_num, i0.round_key}, 0);
                q1.delete(); q0.delete(); pend1 = 0; pend0 = 0;
                @(posedge clk); #1;
                rst_n = 1;
                return;
            end else begin
                if (ign_at != 0 && !ignored && i1.round_num == 5'(ign_at)) begin
                    start = 1; key_in = ~k; ignored = 1;
                end
                if (stall_at != 0 && !stalled && i1.round_num == 5'(stall_at)) begin
                    stall = 3; stalled = 1;
                end
                key_ready = (stall > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
                if (stall > 0) stall--;
            end
            @(posedge clk); #1;
        end
        start = 0;
        if (!fin) chk("timeout_done", i1.done, 1);
        else chk("start_with_done_ignored", {i1.key_valid, i0.key_valid}, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; key_in = '0; key_ready = 0;
        #2;
        chk("reset_dec", {i1.key_valid, i1.busy, i1.done, i1.key_last, i1.round_num, i1.round_key}, 0);
        chk("reset_enc", {i0.key_valid, i0.busy, i0.done, i0.key_last, i0.round_num, i0.round_key}, 0);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("reset_parity", {i1.key_parity_err, i0.key_parity_err}, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1;
        run_seq(KNOWN, 0, 0, 0, 0);
        run_seq(KNOWN, 12, 8, 0, 0);
        run_seq(KNOWN, 0, 0, 5, 0);
        run_seq(KNOWN, 0, 0, 0, 0);
        run_seq(KNOWN ^ 64'h1, 0, 0, 0, 0);
        for (int n = 0; n < 20; n++)
            run_seq({$urandom, $urandom}, (n % 3 == 0) ? int'($urandom_range(2, 15)) : 0,
                    int'($urandom_range(0, 16)), 0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", q1.size() + q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
